fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined CPU.
- Owns the PC and issues word reads to instruction memory through a single-outstanding-request handshake.
- Registers the returned instruction, its PC and PC+4 into the IF/ID boundary.
- Decode consumes these; the instruction's imm16 field feeds the 16-to-32 sign extender.
- Accepts stall from decode and PC redirect (branch/jump) from execute.

Parameters:
- ADDR_WIDTH, 32, PC and imem address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request, 1-cycle pulse per request.
- imem_addr  output  ADDR_WIDTH  request address, valid when imem_req=1, bits[1:0]=0.
- imem_rvalid  input  1  read data valid, at least 1 cycle after request.
- imem_rdata  input  INSTR_WIDTH  instruction word.
- id_stall  input  1  decode cannot accept; hold IF/ID contents.
- redirect_valid  input  1  execute redirects fetch (taken branch/jump).
- redirect_pc  input  ADDR_WIDTH  redirect target; bits[1:0] ignored (forced 00).
- id_valid  output  1  IF/ID holds a live instruction.
- id_instr  output  INSTR_WIDTH  fetched instruction (NOP=32'h0 when invalid).
- id_pc  output  ADDR_WIDTH  address of id_instr.
- id_pc_plus4  output  ADDR_WIDTH  id_pc+4, modulo 2^ADDR_WIDTH.

Behaviour:
- Reset (synchronous, takes effect at the clock edge, overrides everything):
  - pc=RESET_PC, state=IDLE, discard=0, buffer cleared.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
  - imem_req=0 during the reset cycle.
- Reset mid-request: an rvalid arriving afterwards in IDLE is ignored.
- States: IDLE (no request outstanding), WAIT (one outstanding), HOLD (response captured in buffer, IF/ID blocked).
- "Slot free" = !id_valid || !id_stall.
- IDLE:
  - imem_req=1, imem_addr=pc, next state WAIT.
  - Stray rvalid in IDLE is ignored.
- WAIT, imem_rvalid=1, discard=1: drop data, clear discard, go IDLE.
- WAIT, imem_rvalid=1, discard=0, slot free:
  - id_instr<=rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  - Same cycle: imem_req=1, imem_addr=pc+4; stay WAIT (back-to-back, 1 instr/cycle with 1-cycle memory).
- WAIT, imem_rvalid=1, discard=0, slot busy: buffer<=rdata, go HOLD; no request.
- WAIT, no rvalid: stay WAIT.
- HOLD, slot free: move buffer to IF/ID (pc fields as above), pc<=pc+4, go IDLE.
- IF/ID with id_stall=1 and id_valid=1: all id_* outputs hold.
- id_valid drops to 0 when decode consumes (slot free) and no new instruction is loaded.
- Redirect (highest priority after reset):
  - pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}, id_valid<=0, id_instr<=0; buffer discarded.
  - In WAIT without rvalid the same cycle: discard<=1, stay WAIT.
  - In WAIT with rvalid the same cycle: that data is dropped, go IDLE.
  - In IDLE or HOLD: go IDLE; no request issued in the redirect cycle.
  - Redirect overrides id_stall (flush wins).
- PC wrap: 32'hFFFF_FFFC+4=32'h0; no flag.
- At most one request outstanding at any time.

Decomposition:
- cpu_pkg:
  - fetch_state_t enum {IDLE, WAIT, HOLD}.
  - NOP_INSTR=32'h0000_0000.
  - PC_STEP=4.
- Sub-module if_id_reg: IF/ID register with load, hold and flush controls, reset values as above. Instantiated once.

Test Plan:
- Reset with RESET_PC=0; memory 1-cycle latency returning addr^32'hA5A5_0000 -> first req addr 0 the cycle after reset deasserts; id_pc sequence 0,4,8 on consecutive cycles with matching id_instr.
- id_stall=1 for 3 cycles while a response arrives -> state HOLD; id_* unchanged; no imem_req; after release the buffered word appears with id_pc=prev+4.
- Redirect to 32'h0000_0103 while WAIT, rvalid 2 cycles later -> id_valid=0 next cycle; the late word is never presented; next req addr=32'h0000_0100.
- Redirect coincident with rvalid and id_stall=1 -> data dropped, id_valid=0; next req addr=redirect target.
- RESET_PC=32'hFFFF_FFF8 -> id_pc 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0; id_pc_plus4 of the last fetch is 32'h4.
- Reset asserted during WAIT, rvalid arrives after -> id_valid=0; the stray word is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline stages.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it while decode
// stalls, or flush it to a NOP bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   flush,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    input  logic [ADDR_WIDTH-1:0]  load_pc,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pc_plus4
);

    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pc_plus4_q, pc_plus4_d;

    // Flush beats load; an unstalled slot with nothing new becomes a bubble.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = INSTR_WIDTH'(NOP_INSTR);
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = load_instr;
            pc_d       = load_pc;
            pc_plus4_d = load_pc + ADDR_WIDTH'(PC_STEP);
        end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = INSTR_WIDTH'(NOP_INSTR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one imem read in flight and
// feeds the IF/ID register, honouring decode stalls and execute redirects.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   id_stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pc_plus4
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   discard_q, discard_d;
    logic [INSTR_WIDTH-1:0] buf_q, buf_d;

    logic                   if_load;
    logic                   if_flush;
    logic [INSTR_WIDTH-1:0] load_instr;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic                   slot_free;

    assign pc_next   = pc_q + ADDR_WIDTH'(PC_STEP);
    assign slot_free = !id_valid || !id_stall;

    // Redirect flushes everything; a request already in flight is either
    // dropped now (data arriving) or marked so its late response is discarded.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        buf_d      = buf_q;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        if_load    = 1'b0;
        if_flush   = 1'b0;
        load_instr = buf_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            if_flush = 1'b1;
            buf_d    = '0;
            if (state_q == WAIT && !imem_rvalid) begin
                discard_d = 1'b1;
                state_d   = WAIT;
            end else begin
                discard_d = 1'b0;
                state_d   = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    imem_req  = 1'b1;
                    imem_addr = pc_q;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = IDLE;
                        end else if (slot_free) begin
                            if_load    = 1'b1;
                            load_instr = imem_rdata;
                            pc_d       = pc_next;
                            imem_req   = 1'b1;
                            imem_addr  = pc_next;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        if_load    = 1'b1;
                        load_instr = buf_q;
                        pc_d       = pc_next;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (reset) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC & ALIGN_MASK;
            discard_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            buf_q     <= buf_d;
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load       (if_load),
        .flush      (if_flush),
        .stall      (id_stall),
        .load_instr (load_instr),
        .load_pc    (pc_q),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small imem model answers each request with
// addr ^ 32'hA5A5_0000 after a programmable latency.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    logic        reset2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2 = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc2;
    logic [31:0] id_pc_plus42;

    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4)
    );

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk           (clk),
        .reset         (reset2),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_rvalid   (imem_rvalid2),
        .imem_rdata    (imem_rdata2),
        .id_stall      (1'b0),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .id_valid      (id_valid2),
        .id_instr      (id_instr2),
        .id_pc         (id_pc2),
        .id_pc_plus4   (id_pc_plus42)
    );

    // Memory for the main DUT: a new request replaces any pending one.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req) begin
            if (mem_lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= imem_addr ^ KEY;
                pend_cnt    <= 0;
            end else begin
                pend_addr <= imem_addr;
                pend_cnt  <= mem_lat - 1;
            end
        end else if (pend_cnt != 0) begin
            if (pend_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= pend_addr ^ KEY;
            end
            pend_cnt <= pend_cnt - 1;
        end
    end

    always @(posedge clk) begin
        imem_rvalid2 <= imem_req2;
        imem_rdata2  <= imem_addr2 ^ KEY;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        tick();
        tick();
        reset2 = 1'b0;
        #1;
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_first_req: req=%0b addr=%08h expected req=1 addr=fffffff8", imem_req2, imem_addr2); end
        tick();
        #1;
        checks++; if (imem_addr2 !== 32'hFFFF_FFFC || id_valid2 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_second_req: addr=%08h valid=%0b expected fffffffc valid=0", imem_addr2, id_valid2); end
        tick();
        #1;
        checks++; if (id_valid2 !== 1'b1 || id_pc2 !== 32'hFFFF_FFF8 || id_pc_plus42 !== 32'hFFFF_FFFC || id_instr2 !== 32'h5A5A_FFF8) begin errors++; $display("[TB] FAIL wrap_id0: v=%0b pc=%08h p4=%08h instr=%08h expected 1 fffffff8 fffffffc 5a5afff8", id_valid2, id_pc2, id_pc_plus42, id_instr2); end
        tick();
        #1;
        checks++; if (id_pc2 !== 32'hFFFF_FFFC || id_pc_plus42 !== 32'h0000_0000 || id_instr2 !== 32'h5A5A_FFFC) begin errors++; $display("[TB] FAIL wrap_id1: pc=%08h p4=%08h instr=%08h expected fffffffc 00000000 5a5afffc", id_pc2, id_pc_plus42, id_instr2); end
        tick();
        #1;
        checks++; if (id_pc2 !== 32'h0000_0000 || id_pc_plus42 !== 32'h0000_0004 || id_instr2 !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL wrap_id2: pc=%08h p4=%08h instr=%08h expected 00000000 00000004 a5a50000", id_pc2, id_pc_plus42, id_instr2); end
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_ifid: v=%0b instr=%08h pc=%08h p4=%08h expected all zero", id_valid, id_instr, id_pc, id_pc_plus4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: req=%0b expected 0", imem_req); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req: req=%0b addr=%08h expected req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0;
        exp_pc[1] = 32'h4;
        exp_pc[2] = 32'h8;
        tick();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req4: req=%0b addr=%08h valid=%0b expected 1 00000004 0", imem_req, imem_addr, id_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_instr !== (exp_pc[i] ^ KEY) || id_pc_plus4 !== exp_pc[i] + 32'h4) begin errors++; $display("[TB] FAIL b2b_id%0d: v=%0b pc=%08h instr=%08h p4=%08h expected pc=%08h", i, id_valid, id_pc, id_instr, id_pc_plus4, exp_pc[i]); end
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_capture_req: req=%0b expected 0", imem_req); end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'hA5A5_0008 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d: v=%0b pc=%08h instr=%08h req=%0b expected 1 00000008 a5a50008 0", i, id_valid, id_pc, id_instr, imem_req); end
        end
        tick();
        id_stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || id_pc !== 32'h8) begin errors++; $display("[TB] FAIL stall_release: req=%0b pc=%08h expected 0 00000008", imem_req, id_pc); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'hA5A5_000C || id_pc_plus4 !== 32'h10) begin errors++; $display("[TB] FAIL stall_buffered: v=%0b pc=%08h instr=%08h p4=%08h expected 1 0000000c a5a5000c 00000010", id_valid, id_pc, id_instr, id_pc_plus4); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_next_req: req=%0b addr=%08h expected 1 00000010", imem_req, imem_addr); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL consume_bubble: v=%0b instr=%08h addr=%08h expected 0 00000000 00000014", id_valid, id_instr, imem_addr); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin errors++; $display("[TB] FAIL resume: v=%0b pc=%08h expected 1 00000010", id_valid, id_pc); end
    endtask

    task automatic test_redirect();
        mem_lat = 3;
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_pre: v=%0b pc=%08h req=%0b expected 1 00000014 0", id_valid, id_pc, imem_req); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req: req=%0b expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: v=%0b instr=%08h req=%0b expected 0 0 0", id_valid, id_instr, imem_req); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop_late: v=%0b req=%0b expected 0 0", id_valid, imem_req); end
        tick();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_target_req: req=%0b addr=%08h v=%0b expected 1 00000100 0", imem_req, imem_addr, id_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_wait%0d: v=%0b expected 0", i, id_valid); end
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL redir_b2b_req: req=%0b addr=%08h expected 1 00000104", imem_req, imem_addr); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'hA5A5_0100) begin errors++; $display("[TB] FAIL redir_target_id: v=%0b pc=%08h instr=%08h expected 1 00000100 a5a50100", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_redirect_with_rvalid();
        id_stall = 1'b1;
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("[TB] FAIL rr_hold: v=%0b pc=%08h expected 1 00000100", id_valid, id_pc); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rr_req: req=%0b expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL rr_after: v=%0b instr=%08h req=%0b addr=%08h expected 0 0 1 00000200", id_valid, id_instr, imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_request();
        mem_lat = 2;
        tick();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_wait: req=%0b expected 0", imem_req); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_reset_req: req=%0b expected 0", imem_req); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_restart: req=%0b addr=%08h v=%0b expected 1 00000000 0", imem_req, imem_addr, id_valid); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_stray_ignored: v=%0b req=%0b expected 0 0", id_valid, imem_req); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL rm_accept: v=%0b req=%0b addr=%08h expected 0 1 00000004", id_valid, imem_req, imem_addr); end
        tick();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL rm_first_id: v=%0b pc=%08h instr=%08h expected 1 00000000 a5a50000", id_valid, id_pc, id_instr); end
    endtask

    initial begin
        reset          = 1'b1;
        reset2         = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_wrap();
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_redirect_with_rvalid();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
